// File: rtl/spi_seq_pkg.sv
// ---------------------------------------------------------------------------
// spi_seq_pkg
// Shared definitions for the SPI burst sequencer: default FIFO depth and burst
// length width, and the sequencer state encoding.
// ---------------------------------------------------------------------------
package spi_seq_pkg;

   localparam int DEFAULT_DEPTH = 8;
   localparam int DEFAULT_LEN_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT,
      DONE
   } state_e;

endpackage

// File: rtl/spi_burst_seq_if.sv
// ---------------------------------------------------------------------------
// spi_burst_seq_if
// Byte handshake between the burst sequencer and the SPI master controller.
//   start   : one-cycle request to shift tx_data out
//   tx_data : byte to transmit, held stable until done
//   busy    : master is shifting
//   done    : one-cycle byte-complete pulse
//   rx_data : received byte, valid while done is high
// master modport = sequencer side, slave modport = SPI controller side.
// ---------------------------------------------------------------------------
interface spi_burst_seq_if;

   logic       start;
   logic [7:0] tx_data;
   logic       busy;
   logic       done;
   logic [7:0] rx_data;

   modport master (output start, output tx_data,
                   input  busy,  input  done, input rx_data);

   modport slave  (input  start, input  tx_data,
                   output busy,  output done, output rx_data);

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, synchronous active-low reset
//   wr_en      : push wr_data (dropped while full; full is the pre-pop value)
//   rd_en      : pop the head (ignored while empty)
//   rd_data    : current head, reads 0 while empty
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // NOTE: storage is deliberately not reset; pointers and count alone define
   // which entries are valid, and rd_data is masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses <= so every register samples pre-edge
   // values no matter how the simulator orders the blocks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_burst_seq.sv
// ---------------------------------------------------------------------------
// spi_burst_seq
// Feeds an N-byte burst from a TX FIFO to the SPI master one byte at a time
// and collects the received bytes into an RX FIFO.
//   clk, rst_n          : clock, synchronous active-low reset
//   tx_wr_en/tx_wr_data : TX FIFO push; tx_full, tx_count status
//   cmd_valid/cmd_len   : burst request, accepted while cmd_ready (idle)
//   rx_rd_en            : RX FIFO pop; rx_rd_data (FWFT head), rx_empty,
//                         rx_count status
//   spi                 : start/tx_data/busy/done/rx_data master handshake
//   burst_done          : one-cycle pulse after the last byte completes
//   err                 : one-cycle pulse (registered) for zero-length command,
//                         TX overflow write, or RX underflow read
// ---------------------------------------------------------------------------
module spi_burst_seq
   import spi_seq_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int LEN_W = DEFAULT_LEN_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tx_wr_en,
   input  logic [7:0]             tx_wr_data,
   output logic                   tx_full,
   output logic [$clog2(DEPTH):0] tx_count,
   input  logic                   cmd_valid,
   input  logic [LEN_W-1:0]       cmd_len,
   output logic                   cmd_ready,
   input  logic                   rx_rd_en,
   output logic [7:0]             rx_rd_data,
   output logic                   rx_empty,
   output logic [$clog2(DEPTH):0] rx_count,
   spi_burst_seq_if.master        spi,
   output logic                   burst_done,
   output logic                   err
);

   state_e           state;
   state_e           state_nxt;
   logic [LEN_W-1:0] remaining;
   logic [7:0]       tx_data_q;
   logic             err_q;

   logic       tx_empty;
   logic [7:0] tx_head;
   logic       rx_full;
   logic       rx_room;
   logic       cmd_accept;
   logic       load_go;
   logic       tx_pop;
   logic       rx_push;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (tx_wr_en),
      .wr_data (tx_wr_data),
      .rd_en   (tx_pop),
      .rd_data (tx_head),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (rx_push),
      .wr_data (spi.rx_data),
      .rd_en   (rx_rd_en),
      .rd_data (rx_rd_data),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

   // A byte is only launched once its reply is guaranteed a slot; a pop in the
   // same cycle frees one, so the RX FIFO can never overflow.
   assign rx_room    = !rx_full || (rx_rd_en && !rx_empty);
   assign cmd_accept = cmd_valid && (state == IDLE);
   assign load_go    = (state == LOAD) && !tx_empty && rx_room && !spi.busy;
   assign tx_pop     = (state == START);
   assign rx_push    = (state == WAIT) && spi.done;

   always_comb begin
      // NOTE: default first so every path assigns state_nxt (no latch).
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_accept && (cmd_len != '0)) state_nxt = LOAD;
         LOAD:    if (load_go) state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT:    if (spi.done)
                     state_nxt = (remaining == LEN_W'(1)) ? DONE : LOAD;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
         tx_data_q <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cmd_accept)   remaining <= cmd_len;
         else if (rx_push) remaining <= remaining - LEN_W'(1);
         // Captured on the way into START so the byte is already valid while
         // the start pulse is high; the TX pop in START then retires it.
         if (load_go) tx_data_q <= tx_head;
         err_q <= (tx_wr_en && tx_full) ||
                  (rx_rd_en && rx_empty) ||
                  (cmd_accept && (cmd_len == '0));
      end
   end

   assign cmd_ready   = (state == IDLE);
   assign spi.start   = (state == START);
   assign spi.tx_data = tx_data_q;
   assign burst_done  = (state == DONE);
   assign err         = err_q;

endmodule

// File: tb/tb_spi_burst_seq.sv
// ---------------------------------------------------------------------------
// tb_spi_burst_seq
// Self-checking bench: a queue-based transaction model is compared against the
// DUT every cycle, directed scenarios pin latencies and data with literals, and
// a randomized phase mixes writes, reads, commands and master latencies.
// ---------------------------------------------------------------------------
module tb_spi_burst_seq;

   localparam int DEPTH = 8;
   localparam int LEN_W = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tx_wr_en;
   logic [7:0]    tx_wr_data;
   logic          tx_full;
   logic [CW-1:0] tx_count;
   logic          cmd_valid;
   logic [LEN_W-1:0] cmd_len;
   logic          cmd_ready;
   logic          rx_rd_en;
   logic [7:0]    rx_rd_data;
   logic          rx_empty;
   logic [CW-1:0] rx_count;
   logic          burst_done;
   logic          err;

   spi_burst_seq_if spi ();

   spi_burst_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_wr_en   (tx_wr_en),
      .tx_wr_data (tx_wr_data),
      .tx_full    (tx_full),
      .tx_count   (tx_count),
      .cmd_valid  (cmd_valid),
      .cmd_len    (cmd_len),
      .cmd_ready  (cmd_ready),
      .rx_rd_en   (rx_rd_en),
      .rx_rd_data (rx_rd_data),
      .rx_empty   (rx_empty),
      .rx_count   (rx_count),
      .spi        (spi),
      .burst_done (burst_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- SPI master model ----------------
   int         m_cnt       = 0;
   int         m_tail      = 0;
   int         m_lat_fixed = 3;
   int         m_tail_max  = 0;
   bit         m_inv       = 1'b1;
   logic [7:0] m_byte      = 8'h00;
   int         m_done_cyc[$];

   initial begin
      spi.busy    = 1'b0;
      spi.done    = 1'b0;
      spi.rx_data = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         spi.done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               spi.done    = 1'b1;
               spi.rx_data = m_inv ? ~m_byte : 8'($urandom);
               m_done_cyc.push_back(cyc);
               m_tail   = (m_tail_max > 0) ? $urandom_range(m_tail_max, 0) : 0;
               spi.busy = (m_tail > 0);
            end
         end else if (m_tail > 0) begin
            m_tail--;
            spi.busy = (m_tail > 0);
         end
         if (spi.start) begin
            m_byte   = spi.tx_data;
            spi.busy = 1'b1;
            m_cnt    = (m_lat_fixed > 0) ? m_lat_fixed : $urandom_range(5, 1);
         end
      end
   end

   // ---------------- transaction model + per-cycle compare ----------------
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   bit         md_active  = 1'b0;
   bit         md_out     = 1'b0;
   int         md_rem     = 0;
   logic       md_exp_err = 1'b0;
   logic       md_exp_bd  = 1'b0;
   logic [7:0] md_last_tx = 8'h00;
   bit         chk_on     = 1'b0;

   logic [7:0] start_log[$];
   int         start_cyc[$];
   int         bd_cyc[$];
   int         err_cnt = 0;
   int         rx_max  = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (chk_on) begin
            bit e;
            bit ready_now;
            bit full_before;
            ready_now = !md_active && !md_exp_bd;

            check("tx_count",   tx_count,   tx_q.size());
            check("tx_full",    tx_full,    tx_q.size() == DEPTH);
            check("rx_count",   rx_count,   rx_q.size());
            check("rx_empty",   rx_empty,   rx_q.size() == 0);
            check("rx_rd_data", rx_rd_data, (rx_q.size() > 0) ? rx_q[0] : 8'h00);
            check("err",        err,        md_exp_err);
            check("burst_done", burst_done, md_exp_bd);
            check("cmd_ready",  cmd_ready,  ready_now);
            if (int'(rx_count) > rx_max) rx_max = int'(rx_count);
            if (burst_done) bd_cyc.push_back(cyc);
            if (err) err_cnt++;
            if (spi.start) begin
               check("start_legal", md_active && !md_out && (tx_q.size() > 0), 1);
               check("spi_tx_data", spi.tx_data, (tx_q.size() > 0) ? tx_q[0] : 8'h00);
            end else if (md_out) begin
               check("tx_data_hold", spi.tx_data, md_last_tx);
            end

            if (!rst_n) begin
               tx_q.delete();
               rx_q.delete();
               md_active  = 1'b0;
               md_out     = 1'b0;
               md_rem     = 0;
               md_exp_err = 1'b0;
               md_exp_bd  = 1'b0;
            end else begin
               e           = 1'b0;
               md_exp_bd   = 1'b0;
               full_before = (tx_q.size() == DEPTH);
               if (rx_rd_en) begin
                  if (rx_q.size() == 0) e = 1'b1;
                  else void'(rx_q.pop_front());
               end
               if (spi.done && md_active && md_out) begin
                  rx_q.push_back(spi.rx_data);
                  md_out = 1'b0;
                  md_rem--;
                  if (md_rem == 0) begin
                     md_active = 1'b0;
                     md_exp_bd = 1'b1;
                  end
               end
               if (spi.start) begin
                  start_log.push_back(spi.tx_data);
                  start_cyc.push_back(cyc);
                  md_out = 1'b1;
                  if (tx_q.size() > 0) begin
                     md_last_tx = tx_q[0];
                     void'(tx_q.pop_front());
                  end
               end
               if (tx_wr_en) begin
                  if (full_before) e = 1'b1;
                  else tx_q.push_back(tx_wr_data);
               end
               if (cmd_valid && ready_now) begin
                  if (cmd_len == '0) e = 1'b1;
                  else begin
                     md_active = 1'b1;
                     md_rem    = int'(cmd_len);
                  end
               end
               md_exp_err = e;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
      tx_wr_en  = 1'b0;
      cmd_valid = 1'b0;
      rx_rd_en  = 1'b0;
   endtask

   task automatic wr_tx(input logic [7:0] b);
      tx_wr_en   = 1'b1;
      tx_wr_data = b;
      tick();
   endtask

   task automatic cmd(input int len);
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(len);
      tick();
   endtask

   task automatic rd_rx();
      rx_rd_en = 1'b1;
      tick();
   endtask

   task automatic wait_bd(input int n_before, input int budget, input string name);
      int i;
      i = 0;
      while (bd_cyc.size() == n_before && i < budget) begin
         tick();
         i++;
      end
      check({name, "_bd_seen"}, bd_cyc.size() > n_before, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int n0, b0, d0, e0, acc, i;
      rst_n      = 1'b0;
      tx_wr_en   = 1'b0;
      tx_wr_data = 8'h00;
      cmd_valid  = 1'b0;
      cmd_len    = '0;
      rx_rd_en   = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk_on = 1'b1;

      // reset state
      check("rst_cmd_ready",  cmd_ready,   1);
      check("rst_spi_start",  spi.start,   0);
      check("rst_tx_data",    spi.tx_data, 8'h00);
      check("rst_rx_rd_data", rx_rd_data,  8'h00);
      check("rst_rx_empty",   rx_empty,    1);
      check("rst_tx_count",   tx_count,    0);
      rst_n = 1'b1;
      tick();

      // 1: three-byte burst, inverted echo, latency pins
      m_inv = 1'b1; m_lat_fixed = 3; m_tail_max = 0;
      wr_tx(8'hA5); wr_tx(8'h3C); wr_tx(8'hFF);
      n0 = start_log.size(); b0 = bd_cyc.size(); d0 = m_done_cyc.size();
      acc = cyc;
      cmd(3);
      wait_bd(b0, 100, "t1");
      check("t1_ready_k2",   cmd_ready, 1);
      tick();
      check("t1_nstarts",    start_log.size() - n0, 3);
      check("t1_tx0",        start_log[n0],   8'hA5);
      check("t1_tx1",        start_log[n0+1], 8'h3C);
      check("t1_tx2",        start_log[n0+2], 8'hFF);
      check("t1_first_lat",  start_cyc[n0] - acc, 2);
      check("t1_next_lat",   start_cyc[n0+1] - m_done_cyc[d0], 2);
      check("t1_bd_lat",     bd_cyc[b0] - m_done_cyc[d0+2], 1);
      check("t1_nbd",        bd_cyc.size() - b0, 1);
      check("t1_rx0", rx_rd_data, 8'h5A); rd_rx();
      check("t1_rx1", rx_rd_data, 8'hC3); rd_rx();
      check("t1_rx2", rx_rd_data, 8'h00); rd_rx();
      check("t1_rx_empty", rx_empty, 1);

      // 2: burst with starved TX FIFO
      n0 = start_log.size(); b0 = bd_cyc.size();
      cmd(2);
      repeat (20) tick();
      check("t2_stall",     start_log.size() - n0, 0);
      check("t2_not_ready", cmd_ready, 0);
      wr_tx(8'h11); wr_tx(8'h22);
      wait_bd(b0, 100, "t2");
      check("t2_nstarts", start_log.size() - n0, 2);
      check("t2_tx0", start_log[n0],   8'h11);
      check("t2_tx1", start_log[n0+1], 8'h22);
      check("t2_rx0", rx_rd_data, 8'hEE); rd_rx();
      check("t2_rx1", rx_rd_data, 8'hDD); rd_rx();

      // 3: RX back-pressure, prefill 7 then burst of 2
      for (int j = 0; j < 7; j++) wr_tx(8'(j + 1));
      b0 = bd_cyc.size();
      cmd(7);
      wait_bd(b0, 200, "t3a");
      check("t3_prefill", rx_count, 7);
      wr_tx(8'h40); wr_tx(8'h41);
      n0 = start_log.size(); b0 = bd_cyc.size();
      cmd(2);
      i = 0;
      while (rx_count != 8 && i < 100) begin tick(); i++; end
      check("t3_fill", rx_count, 8);
      repeat (10) tick();
      check("t3_held", start_log.size() - n0, 1);
      rd_rx();
      check("t3_head_after_pop", rx_rd_data, 8'hFD);
      wait_bd(b0, 100, "t3b");
      check("t3_nstarts", start_log.size() - n0, 2);
      check("t3_end_count", rx_count, 8);
      check("t3_rx_max", rx_max, 8);
      repeat (8) rd_rx();
      check("t3_drained", rx_empty, 1);

      // 4: error pulses
      e0 = err_cnt;
      for (int j = 0; j < 9; j++) wr_tx(8'h80 + 8'(j));
      tick(); tick();
      check("t4_ovf_err_cnt", err_cnt - e0, 1);
      check("t4_tx_count",    tx_count, 8);
      b0 = bd_cyc.size();
      cmd(8);
      wait_bd(b0, 200, "t4");
      repeat (8) rd_rx();
      check("t4_rx_empty", rx_empty, 1);
      e0 = err_cnt;
      rd_rx();
      check("t4_unf_err", err, 1);
      tick();
      check("t4_unf_err_cnt", err_cnt - e0, 1);
      check("t4_unf_count", rx_count, 0);
      cmd(0);
      check("t4_len0_err",   err, 1);
      check("t4_len0_ready", cmd_ready, 1);
      tick();

      // 5: reset during WAIT of byte 2 of 4
      m_lat_fixed = 6;
      wr_tx(8'h10); wr_tx(8'h11); wr_tx(8'h12); wr_tx(8'h13);
      n0 = start_log.size(); b0 = bd_cyc.size();
      cmd(4);
      i = 0;
      while (start_log.size() - n0 < 2 && i < 200) begin tick(); i++; end
      check("t5_two_starts", start_log.size() - n0, 2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_cmd_ready",  cmd_ready,   1);
      check("t5_spi_start",  spi.start,   0);
      check("t5_tx_data",    spi.tx_data, 8'h00);
      check("t5_tx_count",   tx_count,    0);
      check("t5_tx_full",    tx_full,     0);
      check("t5_rx_count",   rx_count,    0);
      check("t5_rx_empty",   rx_empty,    1);
      check("t5_rx_rd_data", rx_rd_data,  8'h00);
      check("t5_burst_done", burst_done,  0);
      check("t5_err",        err,         0);
      repeat (10) tick();
      check("t5_late_done_ignored", rx_count, 0);
      check("t5_no_more_starts",    start_log.size() - n0, 2);
      check("t5_no_bd",             bd_cyc.size() - b0, 0);
      m_lat_fixed = 3;
      wr_tx(8'h5A);
      b0 = bd_cyc.size();
      cmd(1);
      wait_bd(b0, 100, "t5");
      check("t5_new_rx", rx_rd_data, 8'hA5);
      rd_rx();

      // 6: simultaneous RX push and pop at rx_count = 4
      for (int j = 0; j < 4; j++) wr_tx(8'hA0 + 8'(j));
      b0 = bd_cyc.size();
      cmd(4);
      wait_bd(b0, 200, "t6a");
      check("t6_count4", rx_count, 4);
      wr_tx(8'hB0);
      cmd(1);
      i = 0;
      while (spi.done !== 1'b1 && i < 50) begin tick(); i++; end
      check("t6_done_seen", spi.done, 1);
      rx_rd_en = 1'b1;
      tick();
      check("t6_count_kept", rx_count, 4);
      check("t6_rx0", rx_rd_data, 8'h5E); rd_rx();
      check("t6_rx1", rx_rd_data, 8'h5D); rd_rx();
      check("t6_rx2", rx_rd_data, 8'h5C); rd_rx();
      check("t6_rx3", rx_rd_data, 8'h4F); rd_rx();
      tick(); tick();

      // 7: randomized traffic against the model
      m_inv = 1'b0; m_lat_fixed = 0; m_tail_max = 2;
      for (int j = 0; j < 3000; j++) begin
         tx_wr_en   = ($urandom_range(99) < 45);
         tx_wr_data = 8'($urandom);
         rx_rd_en   = ($urandom_range(99) < 35);
         cmd_valid  = ($urandom_range(99) < 15);
         cmd_len    = LEN_W'($urandom);
         tick();
      end
      i = 0;
      while ((md_active || md_exp_bd) && i < 2000) begin
         tx_wr_en   = (tx_q.size() < 4);
         tx_wr_data = 8'($urandom);
         rx_rd_en   = (rx_q.size() > 0);
         tick();
         i++;
      end
      check("rand_burst_drained", md_active, 0);
      i = 0;
      while (rx_q.size() > 0 && i < 100) begin rd_rx(); i++; end
      tick();
      check("rand_rx_empty", rx_empty, 1);
      check("rand_rx_max_bound", rx_max <= DEPTH, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
